window_line_buffer: RTL and testbench
=====================================

# window_line_buffer

Parametrised sliding-window generator for the edge-detection pipeline. Accepts a raster stream of pixel words and buffers ROWS-1 previous lines in on-chip line memories. Presents a full ROWS x COLS neighbourhood, registered, with a valid strobe that suppresses windows straddling a line wrap or lying above the first complete row set. Sits between the pixel input stage and the convolution/gradient kernels, generalising the fixed 3x3, 32-bit, fixed-line-length window path.

## Interface

Parameters:
- DATA_W, 32, bits per pixel word
- LINE_W, 78, words per image line (>= COLS)
- ROWS, 3, window height (>= 2)
- COLS, 3, window width (>= 1)
- XW, $clog2(LINE_W), column index width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  word on in_data accepted this cycle
- in_sof  in  1  qualifies in_valid: accepted word is pixel (0,0) of a new frame
- in_data  in  DATA_W  pixel word
- win  out  ROWS*COLS*DATA_W  window, element (r,c) at bits [(r*COLS+c)*DATA_W +: DATA_W]; r=0 newest line, c=0 newest column
- out_valid  out  1  win holds a complete, non-wrapping window
- out_x  out  XW  column index of element (0,0) of win

## Operation

- Counters: col (0..LINE_W-1), row (saturating 0..ROWS-1). Advance only on accepted word (in_valid=1).
- Accept with in_sof=1: word treated as col=0,row=0; counters afterwards col=1,row=0. Line memory contents untouched.
- Accept without in_sof: word at current col; then col wraps LINE_W-1 -> 0, incrementing row (saturating at ROWS-1); otherwise col+1.
- Line memories L[0..ROWS-2], each LINE_W x DATA_W, addressed by current col. On accept: tap[0]=in_data, tap[k]=L[k-1][col] (old contents, read-before-write); L[0][col]<=in_data; L[k][col]<=tap[k].
- Window registers: on accept, win(r,0)<=tap[r]; win(r,c)<=win(r,c-1) for c>0. Held when in_valid=0.
- out_valid<=1 on the cycle after an accept whose word position satisfies row==ROWS-1 and col>=COLS-1 (position evaluated with in_sof applied); else 0. out_x<=that word's col on every accept.
- Windows with col<COLS-1 contain stale previous-line data; out_valid masks them, contents undefined to consumers.
- Line memories are not reset; only window regs, counters and outputs are.

## Timing

- Reset values: win=0, out_valid=0, out_x=0, col=0, row=0. Asserting rst mid-line discards position; next frame must be restarted (in_sof or post-reset word is (0,0)).
- Latency: accepted word visible at win(0,0) one cycle later; out_valid is a single-cycle pulse per qualifying accept.
- Throughput: one word per cycle, no backpressure; in_valid gaps of any length allowed.
- rst dominates in_valid/in_sof in the same cycle.
- First valid window of a frame: after accept of word index (ROWS-1)*LINE_W+COLS-1.
- Per line after row saturation: LINE_W-COLS+1 valid pulses.

## Test plan

Use DATA_W=8, LINE_W=4, ROWS=3, COLS=3; pixel value = raster index.
- Reset: hold rst, drive in_valid=1 -> win=0, out_valid=0, out_x=0; release, first word (in_sof=1) lands at win(0,0) next cycle.
- Fill: stream 0..11 back-to-back, in_sof on 0 -> out_valid first high the cycle after 10: rows (r0..r2, c0..c2) 10,9,8 / 6,5,4 / 2,1,0, out_x=2; after 11: 11,10,9 / 7,6,5 / 3,2,1, out_x=3.
- Wrap: continue 12,13,14 -> out_valid=0 after 12 and 13; after 14: 14,13,12 / 10,9,8 / 6,5,4, out_x=2.
- Stall: insert 5 idle cycles between 10 and 11 -> win stays 10,9,8/…, out_valid high for exactly one cycle after 10 and one after 11.
- Restart: after 6 words assert in_sof with value 100, then 101.. -> no out_valid until the 11th word after restart; first window row r0 = 110,109,108.
- Async reset: assert rst between clock edges mid-line -> out_valid and win clear immediately without a clock edge; new frame then behaves as the Fill scenario.

Source files
------------

// File: rtl/window_line_buffer.sv
// Sliding ROWS x COLS window generator over a raster pixel stream.
// Keeps ROWS-1 previous lines in line memories and flags complete windows.
module window_line_buffer #(
    parameter int DATA_W = 32,
    parameter int LINE_W = 78,
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int XW     = $clog2(LINE_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_sof,
    input  logic [DATA_W-1:0]           in_data,
    output logic [ROWS*COLS*DATA_W-1:0] win,
    output logic                        out_valid,
    output logic [XW-1:0]               out_x
);

    localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;

    logic [XW-1:0]     col;
    logic [XW-1:0]     pos_col;
    logic [XW-1:0]     nxt_col;
    logic [RW-1:0]     row;
    logic [RW-1:0]     pos_row;
    logic [RW-1:0]     nxt_row;
    logic              win_ok;
    logic [DATA_W-1:0] mem   [ROWS-1][LINE_W];
    logic [DATA_W-1:0] tap   [ROWS];
    logic [DATA_W-1:0] win_q [ROWS][COLS];

    // Position of the accepted word (sof forces 0,0), next position and memory taps
    always_comb begin
        pos_col = in_sof ? '0 : col;
        pos_row = in_sof ? '0 : row;
        nxt_col = pos_col + 1'b1;
        nxt_row = pos_row;
        if (pos_col == XW'(LINE_W - 1)) begin
            nxt_col = '0;
            if (pos_row != RW'(ROWS - 1))
                nxt_row = pos_row + 1'b1;
        end
        win_ok = (pos_row == RW'(ROWS - 1)) &&
                 (pos_col >= XW'(COLS - 1));
        tap[0] = in_data;
        for (int k = 1; k < ROWS; k++)
            tap[k] = mem[k-1][pos_col];
    end

    // Column and saturating row counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            col <= nxt_col;
            row <= nxt_row;
        end
    end

    // Line memories: each line shifts one memory deeper at the same column
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            for (int k = 0; k < ROWS - 1; k++)
                mem[k][pos_col] <= tap[k];
        end
    end

    // Window shift register: new column enters at c=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    win_q[r][c] <= '0;
        end else if (in_valid) begin
            for (int r = 0; r < ROWS; r++) begin
                win_q[r][0] <= tap[r];
                for (int c = 1; c < COLS; c++)
                    win_q[r][c] <= win_q[r][c-1];
            end
        end
    end

    // Valid pulse and column index of the newest window element
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= '0;
        end else begin
            out_valid <= in_valid && win_ok;
            if (in_valid)
                out_x <= pos_col;
        end
    end

    // Flatten window registers onto the output bus
    always_comb begin
        win = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                win[(r*COLS+c)*DATA_W +: DATA_W] = win_q[r][c];
    end

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer with a 4-word line and 3x3 window.
// Pixel values equal raster index; expected windows are hand computed.
module tb_window_line_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_data;
    logic [71:0] win;
    logic        out_valid;
    logic [1:0]  out_x;

    int checks = 0;
    int errors = 0;

    window_line_buffer #(
        .DATA_W(8),
        .LINE_W(4),
        .ROWS(3),
        .COLS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_sof(in_sof),
        .in_data(in_data),
        .win(win),
        .out_valid(out_valid),
        .out_x(out_x)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    function automatic logic [71:0] w9(
        input logic [7:0] a, b, c,
        input logic [7:0] d, e, f,
        input logic [7:0] g, h, i
    );
        return {i, h, g, f, e, d, c, b, a};
    endfunction

    task automatic chk(input string tag,
                       input logic [71:0] obs,
                       input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic s,
                        input logic [7:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = 8'd55;

        // Reset held with in_valid high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_win", win, '0);
        chk("rst_valid", {71'd0, out_valid}, 72'd0);
        chk("rst_x", {70'd0, out_x}, 72'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Fill and wrap: 0..14 back to back
        for (int i = 0; i < 15; i++) begin
            step(1'b1, i == 0, 8'(i));
            chk($sformatf("fill_valid_%0d", i), {71'd0, out_valid},
                {71'd0, (i == 10 || i == 11 || i == 14)});
            chk($sformatf("fill_x_%0d", i), {70'd0, out_x},
                {70'd0, 2'(i % 4)});
            if (i == 0)
                chk("first_word", {64'd0, win[7:0]}, 72'd0);
            if (i == 1)
                chk("shift_1", {56'd0, win[15:0]}, {56'd0, 8'd0, 8'd1});
            if (i == 10)
                chk("win_10", win, w9(10, 9, 8, 6, 5, 4, 2, 1, 0));
            if (i == 11)
                chk("win_11", win, w9(11, 10, 9, 7, 6, 5, 3, 2, 1));
            if (i == 14)
                chk("win_14", win, w9(14, 13, 12, 10, 9, 8, 6, 5, 4));
        end

        // Stall between 10 and 11
        sync_reset();
        for (int i = 0; i <= 10; i++)
            step(1'b1, i == 0, 8'(i));
        chk("stall_v10", {71'd0, out_valid}, 72'd1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 8'hEE);
            chk($sformatf("stall_idle_v%0d", k), {71'd0, out_valid}, 72'd0);
            chk($sformatf("stall_idle_w%0d", k), win,
                w9(10, 9, 8, 6, 5, 4, 2, 1, 0));
        end
        step(1'b1, 1'b0, 8'd11);
        chk("stall_v11", {71'd0, out_valid}, 72'd1);
        chk("stall_w11", win, w9(11, 10, 9, 7, 6, 5, 3, 2, 1));
        step(1'b0, 1'b0, 8'hEE);
        chk("stall_after11", {71'd0, out_valid}, 72'd0);

        // Restart mid-frame with sof
        sync_reset();
        for (int i = 0; i < 6; i++)
            step(1'b1, i == 0, 8'(i));
        for (int i = 0; i < 11; i++) begin
            step(1'b1, i == 0, 8'(100 + i));
            chk($sformatf("restart_v%0d", i), {71'd0, out_valid},
                {71'd0, i == 10});
        end
        chk("restart_win", win,
            w9(110, 109, 108, 106, 105, 104, 102, 101, 100));
        chk("restart_x", {70'd0, out_x}, 72'd2);

        // Asynchronous reset between edges while out_valid is high
        #2;
        rst = 1'b1;
        #1;
        chk("async_win", win, '0);
        chk("async_valid", {71'd0, out_valid}, 72'd0);
        chk("async_x", {70'd0, out_x}, 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk($sformatf("post_v%0d", i), {71'd0, out_valid},
                {71'd0, (i == 10 || i == 11)});
            if (i == 10)
                chk("post_w10", win, w9(10, 9, 8, 6, 5, 4, 2, 1, 0));
            if (i == 11)
                chk("post_w11", win, w9(11, 10, 9, 7, 6, 5, 3, 2, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
